// File: rtl/pwm_key_ctrl.sv
// Two-key PWM duty controller: synchronised, debounced inc/dec keys drive a
// press/hold/auto-repeat FSM that steps a saturating duty register.
module pwm_key_ctrl #(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int INIT_DUTY    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic             pwm_out_o,
  output logic [WIDTH:0]   duty_o,
  output logic             at_max_o,
  output logic             at_min_o
);

  localparam int DBW  = $clog2(DEBOUNCE + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [WIDTH:0] DUTY_MAX  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] DUTY_INIT = (WIDTH+1)'(INIT_DUTY);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_LOCK} state_e;

  // Key vectors: bit 0 is inc, bit 1 is dec.
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          db_q, db_d, db_prev_q;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          rise;
  logic                held;

  state_e              state_q;
  logic [TW-1:0]       timer_q;
  logic                step_q;
  logic                dir_q;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]      pend_q, pend_d;
  logic [WIDTH:0]      active_q, active_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] == db_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DBW'(DEBOUNCE - 1)) begin
        db_d[k]     = sync2_q[k];
        db_cnt_d[k] = '0;
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= {dec_i, inc_i};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign rise = db_q & ~db_prev_q;
  assign held = dir_q ? db_q[1] : db_q[0];

  // Both keys down is checked ahead of the per-state behaviour so LOCK wins from anywhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (&db_q) begin
        state_q <= S_LOCK;
        timer_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rise[0] || rise[1]) begin
              step_q  <= 1'b1;
              dir_q   <= ~rise[0];
              timer_q <= TW'(REPEAT_DELAY);
              state_q <= S_HOLD;
            end
          end
          S_HOLD, S_REPEAT: begin
            if (!held) begin
              state_q <= S_IDLE;
              timer_q <= '0;
            end else if (timer_q <= TW'(1)) begin
              step_q  <= 1'b1;
              timer_q <= TW'(REPEAT_RATE);
              state_q <= S_REPEAT;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          S_LOCK: begin
            if (db_q == 2'b00) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (step_q) begin
      if (!dir_q && pend_q != DUTY_MAX) pend_d = pend_q + 1'b1;
      else if (dir_q && pend_q != '0)   pend_d = pend_q - 1'b1;
    end
    cnt_d    = cnt_q + 1'b1;
    // Active duty only follows pending duty as the counter wraps, keeping each period intact.
    active_d = (cnt_q == '1) ? pend_q : active_q;
    pwm_d    = ({1'b0, cnt_d} < active_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pend_q   <= DUTY_INIT;
      active_q <= DUTY_INIT;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out_o = pwm_q;
  assign duty_o    = active_q;
  assign at_max_o  = (pend_q == DUTY_MAX);
  assign at_min_o  = (pend_q == '0);

endmodule

// File: tb/tb_pwm_key_ctrl.sv
// Bench for pwm_key_ctrl: a behavioural model (window debounce, hold-age step
// schedule, clamped duty) is checked against the DUT every cycle, plus directed literals.
module tb_pwm_key_ctrl;

  localparam int WIDTH = 4;
  localparam int DB    = 4;
  localparam int RD    = 16;
  localparam int RR    = 4;
  localparam int INIT  = 8;
  localparam int P     = 1 << WIDTH;
  localparam int MASK  = (1 << DB) - 1;

  logic           clk = 1'b0;
  logic           rst_n, inc_i, dec_i;
  logic           pwm_out_o, at_max_o, at_min_o;
  logic [WIDTH:0] duty_o;

  int checks   = 0;
  int failures = 0;
  bit m_valid  = 1'b0;

  always #5 clk = ~clk;

  pwm_key_ctrl #(
    .WIDTH(WIDTH), .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .INIT_DUTY(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc_i(inc_i), .dec_i(dec_i),
    .pwm_out_o(pwm_out_o), .duty_o(duty_o), .at_max_o(at_max_o), .at_min_o(at_min_o)
  );

  typedef struct {
    int             pend;
    int             act;
    int             cnt;
    bit             pwm;
    bit [1:0]       db;
    bit [1:0]       prev;
    bit [1:0]       d1;
    bit [1:0]       d2;
    bit [1:0][15:0] win;
    bit             locked;
    int             held;   // 0 none, 1 inc, 2 dec
    int             age;    // edges since the press step
    int             step;   // +1, -1 or 0, lands in pend on the next edge
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, logic rn, logic ki, logic kd);
    mstate_t n;
    n = s;
    if (!rn) begin
      n.pend = INIT; n.act = INIT; n.cnt = 0; n.pwm = 1'b0;
      n.db = '0; n.prev = '0; n.d1 = '0; n.d2 = '0; n.win = '0;
      n.locked = 1'b0; n.held = 0; n.age = 0; n.step = 0;
      return n;
    end
    if (s.cnt == P - 1) n.act = s.pend;
    n.pend = s.pend + s.step;
    if (n.pend > P) n.pend = P;
    if (n.pend < 0) n.pend = 0;
    n.cnt = (s.cnt + 1) % P;
    n.pwm = (n.cnt < n.act);
    n.step = 0;
    if (s.db == 2'b11) begin
      n.locked = 1'b1;
      n.held   = 0;
    end else if (s.locked) begin
      if (s.db == 2'b00) n.locked = 1'b0;
    end else if (s.held == 0) begin
      if (s.db[0] && !s.prev[0]) begin
        n.held = 1; n.age = 0; n.step = 1;
      end else if (s.db[1] && !s.prev[1]) begin
        n.held = 2; n.age = 0; n.step = -1;
      end
    end else if (!s.db[s.held-1]) begin
      n.held = 0;
    end else begin
      n.age = s.age + 1;
      if (n.age == RD || (n.age > RD && (n.age - RD) % RR == 0))
        n.step = (s.held == 1) ? 1 : -1;
    end
    n.prev = s.db;
    for (int k = 0; k < 2; k++) begin
      n.win[k] = {s.win[k][14:0], s.d2[k]};
      if ((int'(n.win[k]) & MASK) == (s.db[k] ? 0 : MASK)) n.db[k] = ~s.db[k];
    end
    n.d2 = s.d1;
    n.d1 = {kd, ki};
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst_n, inc_i, dec_i);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("duty", 32'(duty_o), m.act);
      check("pwm_out", 32'(pwm_out_o), 32'(m.pwm));
      check("at_max", 32'(at_max_o), (m.pend == P) ? 1 : 0);
      check("at_min", 32'(at_min_o), (m.pend == 0) ? 1 : 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align(input int x);
    int n = 0;
    while (m.cnt != x && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("align_timeout", (n < 40) ? 1 : 0, 1);
  endtask

  task automatic count_pwm(output int ones);
    ones = 0;
    repeat (P) begin
      @(negedge clk);
      ones += int'(pwm_out_o);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    check("reset_duty", 32'(duty_o), INIT);
    check("reset_pwm", 32'(pwm_out_o), 0);
    rst_n = 1'b1;
    cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int ones;
    rst_n = 1'b0; inc_i = 1'b0; dec_i = 1'b0;
    cycles(3);
    m_valid = 1'b1;
    check("por_duty", 32'(duty_o), 8);
    check("por_pwm", 32'(pwm_out_o), 0);
    check("por_at_max", 32'(at_max_o), 0);
    check("por_at_min", 32'(at_min_o), 0);
    rst_n = 1'b1;
    cycles(32);
    count_pwm(ones);
    check("idle_pwm_ones", ones, 8);
    check("idle_duty", 32'(duty_o), 8);

    // Clean 10-cycle inc press, timed so the step lands just before a wrap.
    align(7);
    inc_i = 1'b1;
    cycles(7);
    check("model_pend_p6", m.pend, 8);
    cycles(1);
    check("model_pend_p7", m.pend, 9);
    cycles(1);
    check("duty_at_wrap", 32'(duty_o), 9);
    cycles(1);
    inc_i = 1'b0;
    cycles(40);
    check("clean_single_step", 32'(duty_o), 9);

    // Bouncing press gives one step.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      inc_i = (i % 2 == 0);
      cycles(1);
    end
    inc_i = 1'b1;
    cycles(10);
    inc_i = 1'b0;
    cycles(40);
    check("bounce_single_step", 32'(duty_o), 9);

    // Long inc hold into saturation.
    do_reset();
    align(8);
    inc_i = 1'b1;
    cycles(8);
    check("hold_pend_p7", m.pend, 9);
    cycles(16);
    check("hold_pend_p23", m.pend, 10);
    cycles(4);
    check("hold_pend_p27", m.pend, 11);
    cycles(32);
    inc_i = 1'b0;
    check("sat_at_max", 32'(at_max_o), 1);
    cycles(20);
    count_pwm(ones);
    check("sat_pwm_ones", ones, 16);
    check("sat_duty", 32'(duty_o), 16);

    // Long dec hold down to zero.
    do_reset();
    dec_i = 1'b1;
    cycles(44);
    check("dec_pend_p43", m.pend, 1);
    cycles(4);
    check("dec_pend_p47", m.pend, 0);
    cycles(12);
    dec_i = 1'b0;
    cycles(20);
    count_pwm(ones);
    check("zero_pwm_ones", ones, 0);
    check("zero_duty", 32'(duty_o), 0);
    check("zero_at_min", 32'(at_min_o), 1);
    check("zero_at_max", 32'(at_max_o), 0);

    // Both keys: LOCK, partial release, fresh press, reset mid-repeat.
    do_reset();
    inc_i = 1'b1; dec_i = 1'b1;
    cycles(20);
    check("lock_pend", m.pend, 8);
    dec_i = 1'b0;
    cycles(20);
    check("lock_release_dec", m.pend, 8);
    inc_i = 1'b0;
    cycles(20);
    check("lock_release_both", 32'(duty_o), 8);
    inc_i = 1'b1;
    cycles(10);
    inc_i = 1'b0;
    cycles(40);
    check("fresh_press", 32'(duty_o), 9);
    inc_i = 1'b1;
    cycles(30);
    check("repeat_pend", m.pend, 12);
    rst_n = 1'b0;
    cycles(1);
    check("reset_mid_repeat", 32'(duty_o), 8);
    check("reset_mid_at_max", 32'(at_max_o), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(15);
    inc_i = 1'b0;
    cycles(40);
    check("held_through_reset", 32'(duty_o), 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_key_ctrl.md
PWM_KEY_CTRL -- requirements
Module: pwm_key_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the PWM counter width; period = 2^WIDTH clocks.
REQ-002 Parameter DEBOUNCE, default 4, is the number of consecutive stable cycles needed to change a debounced key state.
REQ-003 Parameter REPEAT_DELAY, default 16, is the hold time in cycles from the first step to the first auto-repeat step.
REQ-004 Parameter REPEAT_RATE, default 4, is the number of cycles between auto-repeat steps.
REQ-005 Parameter INIT_DUTY, default 8, is the duty value loaded at reset and must be in the range 0..2^WIDTH.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 inc  input  1  raw, asynchronous, bouncing increase key (active high).
REQ-009 dec  input  1  raw, asynchronous, bouncing decrease key (active high).
REQ-010 pwm_out  output  1  PWM waveform.
REQ-011 duty  output  WIDTH+1  active duty, 0..2^WIDTH.
REQ-012 at_max  output  1  high when pending duty = 2^WIDTH.
REQ-013 at_min  output  1  high when pending duty = 0.

Function
REQ-014 The block SHALL pass inc and dec each through a 2-flop synchronizer before any other use.
REQ-015 Each debounced key SHALL take the synchronized value only after that value has differed from the current debounced state for DEBOUNCE consecutive cycles; any reversion during the count clears the counter.
REQ-016 The block SHALL implement an FSM with states IDLE, HOLD, REPEAT and LOCK.
REQ-017 IDLE: a debounced rise on exactly one key SHALL issue one step in that key's direction, load the repeat timer with REPEAT_DELAY, and go to HOLD.
REQ-018 HOLD: when the timer expires with the same key still held, the FSM SHALL issue one step, load REPEAT_RATE, and go to REPEAT.
REQ-019 REPEAT: the FSM SHALL issue one step every REPEAT_RATE cycles while the key is held.
REQ-020 HOLD or REPEAT: release of the held key SHALL return the FSM to IDLE with no further step.
REQ-021 From any state, both debounced keys high SHALL move the FSM to LOCK with no step; LOCK SHALL exit to IDLE only when both keys are debounced low.
REQ-022 Simultaneous debounced rises of both keys in IDLE SHALL go to LOCK with no step.
REQ-023 A step SHALL change the pending duty by ±1 in the register cycle after the step is issued, saturating at 2^WIDTH and at 0 with no wrap-around.
REQ-024 Steps at saturation SHALL be discarded, and the FSM SHALL continue its sequence unchanged.
REQ-025 The first step SHALL appear in pending duty exactly DEBOUNCE+3 cycles after the first rising edge at which the raw key is sampled high, given a clean key.
REQ-026 The WIDTH-bit period counter SHALL free-run and wrap from 2^WIDTH-1 to 0.
REQ-027 The active duty SHALL load from the pending duty only on the edge where the counter wraps to 0, so a period is never altered mid-cycle.
REQ-028 pwm_out SHALL be registered and equal to (counter < active duty) for the counter value current in that cycle.
REQ-029 As a result, duty 0 SHALL give a constant low output and duty 2^WIDTH a constant high output.
REQ-030 at_max and at_min SHALL be combinational decodes of the pending duty.

Reset
REQ-031 With rst_n low at a clock edge, the block SHALL set pending and active duty to INIT_DUTY.
REQ-032 On the same reset edge: counter = 0, FSM = IDLE, synchronizers and debounced states = 0, debounce and repeat timers = 0, pwm_out = 0.
REQ-033 Reset asserted mid-hold or mid-period SHALL abort immediately with no step issued.
REQ-034 After reset release, a key that is already held SHALL be treated as a new press once it is debounced.

Verification (defaults: WIDTH=4, DEBOUNCE=4, REPEAT_DELAY=16, REPEAT_RATE=4, INIT_DUTY=8)
REQ-035 Reset then idle for 32 cycles -> duty=8 and pwm_out high for 8 of every 16 cycles, with at_max=at_min=0.
REQ-036 inc pulsed clean for 10 cycles -> pending duty becomes 9 exactly 7 cycles after the press, and duty output becomes 9 at the next counter wrap with no further steps.
REQ-037 inc bouncing (toggling each cycle for 6 cycles, then high for 10 cycles) -> exactly one step, from 8 to 9.
REQ-038 inc held for 60 cycles -> steps at press+7, +23, +27, +31, … and saturation at 16 with at_max=1; pwm_out constantly high after the wrap; extra steps are ignored.
REQ-039 dec held past 0 from duty 2 -> duty 1, then 0; at_min=1; pwm_out constantly low; no wrap to 16.
REQ-040 inc and dec held together -> FSM enters LOCK with no duty change; releasing dec only does not step; a fresh inc press after both keys are released steps +1; rst_n low mid-REPEAT restores duty=8.
